// File: rtl/fb_arb_pkg.sv
// Shared constants and the write-buffer entry type
// for the frame-buffer port arbiter.
package fb_arb_pkg;

    localparam int IMG_W    = 320;
    localparam int IMG_H    = 240;
    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 8;
    localparam int DISP_LAT = 3;

    localparam logic [DATA_W-1:0] BG_COLOR = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of frame-buffer write entries.
// Ports: clk, rst (async, active-high), push/din, pop/dout,
// full, empty, level (0..DEPTH).
module fb_wr_fifo
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fb_wr_t           din,
    input  logic             pop,
    output fb_wr_t           dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    fb_wr_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares a single-port frame-buffer RAM between VGA display
// reads (absolute priority) and buffered Sobel writes.
// Ports: clk, rst (async, active-high); pixel_x/pixel_y/
// videoon in, disp_pixel/disp_valid out (3-cycle latency);
// wr_valid/wr_ready/wr_addr/wr_data write handshake;
// ram_en/ram_we/ram_addr/ram_wdata/ram_rdata RAM port;
// fifo_level occupancy; addr_err sticky bad-address flag.
module fb_port_arbiter #(
    parameter int IMG_W      = fb_arb_pkg::IMG_W,
    parameter int IMG_H      = fb_arb_pkg::IMG_H,
    parameter int ADDR_W     = fb_arb_pkg::ADDR_W,
    parameter int DATA_W     = fb_arb_pkg::DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0] BG_COLOR = fb_arb_pkg::BG_COLOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       pixel_x,
    input  logic [10:0]       pixel_y,
    input  logic              videoon,
    output logic [DATA_W-1:0] disp_pixel,
    output logic              disp_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [3:0]        fifo_level,
    output logic              addr_err
);

    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int IMG_PIX = IMG_W * IMG_H;

    logic [31:0]      px32;
    logic [31:0]      py32;
    logic [31:0]      lin_addr;
    logic [ADDR_W-1:0] disp_addr;
    logic             disp_req;

    logic             wr_acc;
    logic             addr_ok;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;

    fb_arb_pkg::fb_wr_t wr_ent;
    fb_arb_pkg::fb_wr_t head;

    logic vid_d1;
    logic req_d1;
    logic vid_d2;
    logic req_d2;

    assign px32      = 32'(pixel_x);
    assign py32      = 32'(pixel_y);
    assign disp_req  = videoon && (px32 < IMG_W)
                    && (py32 < IMG_H);
    assign lin_addr  = py32 * IMG_W + px32;
    assign disp_addr = lin_addr[ADDR_W-1:0];

    // wr_ready depends only on registered level (and reset),
    // never on wr_valid.
    assign wr_ready = !rst && !full;
    assign wr_acc   = wr_valid && wr_ready;
    assign addr_ok  = (32'(wr_addr) < IMG_PIX);
    assign push     = wr_acc && addr_ok;
    // Drain only in slots the display leaves free.
    assign pop      = !disp_req && !empty;

    assign wr_ent.addr = wr_addr;
    assign wr_ent.data = wr_data;

    assign fifo_level = 4'(level);

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wr_ent),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (disp_req) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= disp_addr;
        end else if (!empty) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= head.addr;
            ram_wdata <= head.data;
        end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
        end
    end

    // Two pipeline stages plus the output register give a
    // fixed 3-cycle latency; rdata lines up with stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_d1     <= 1'b0;
            req_d1     <= 1'b0;
            vid_d2     <= 1'b0;
            req_d2     <= 1'b0;
            disp_valid <= 1'b0;
            disp_pixel <= '0;
        end else begin
            vid_d1     <= videoon;
            req_d1     <= disp_req;
            vid_d2     <= vid_d1;
            req_d2     <= req_d1;
            disp_valid <= vid_d2;
            if (req_d2) begin
                disp_pixel <= ram_rdata;
            end else if (vid_d2) begin
                disp_pixel <= BG_COLOR;
            end else begin
                disp_pixel <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (wr_acc && !addr_ok) begin
            addr_err <= 1'b1;
        end
    end

endmodule
